// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes, default widths and the B beat type.
package axi_node_pkg;

    localparam int AXI_ID_W   = 6;
    localparam int AXI_USER_W = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } b_beat_t;

endpackage

// File: rtl/axi_b_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, searched from the slot after the last winner.
module axi_b_rr_arbiter #(
    parameter int N_REQ = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] last_q, last_d;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        found  = 1'b0;
        win    = last_q;
        idx    = '0;
        gnt    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PTR_W'((int'(last_q) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (en && found) gnt[win] = 1'b1;
        // Pointer only advances when the grant is actually consumed.
        last_d = (en && found) ? win : last_q;
    end

    // Reset to the top slot so the first search starts at requestor 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= PTR_W'(N_REQ - 1);
        else        last_q <= last_d;
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule

// File: rtl/axi_b_response_allocator.sv
// B return path for one master port: RR arbitration of slave and DECERR responses into a
// single-entry output register, plus the outstanding-write counter used by the AW decoder.
module axi_b_response_allocator
    import axi_node_pkg::*;
#(
    parameter int N_TARG_PORT     = 8,
    parameter int AXI_ID          = AXI_ID_W,
    parameter int AXI_USER        = AXI_USER_W,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_TARG_PORT-1:0]          bvalid_i,
    input  logic [N_TARG_PORT*AXI_ID-1:0]   bid_i,
    input  logic [N_TARG_PORT*2-1:0]        bresp_i,
    input  logic [N_TARG_PORT*AXI_USER-1:0] buser_i,
    output logic [N_TARG_PORT-1:0]          bready_o,
    output logic                            bvalid_o,
    output logic [AXI_ID-1:0]               bid_o,
    output logic [1:0]                      bresp_o,
    output logic [AXI_USER-1:0]             buser_o,
    input  logic                            bready_i,
    input  logic                            incr_req_i,
    output logic                            full_counter_o,
    output logic                            outstanding_trans_o,
    input  logic                            error_req_i,
    input  logic [AXI_ID-1:0]               error_id_i,
    input  logic [AXI_USER-1:0]             error_user_i,
    output logic                            error_gnt_o
);

    localparam int N_REQ = N_TARG_PORT + 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [N_REQ-1:0]    req, gnt;
    logic                load;
    logic                valid_q, valid_d;
    logic                is_err_q, is_err_d;
    logic [AXI_ID-1:0]   id_q, id_d, mux_id;
    logic [1:0]          resp_q, resp_d, mux_resp;
    logic [AXI_USER-1:0] user_q, user_d, mux_user;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dec;

    assign req  = {error_req_i, bvalid_i};
    // rst_n gating keeps the combinational readies low while reset is held.
    assign load = rst_n && (!valid_q || bready_i) && (|req);

    axi_b_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .en   (load),
        .gnt  (gnt)
    );

    // Grant is one-hot, so an OR-reduction mux is sufficient.
    always_comb begin
        mux_id   = '0;
        mux_resp = '0;
        mux_user = '0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            if (gnt[i]) begin
                mux_id   |= bid_i[i*AXI_ID +: AXI_ID];
                mux_resp |= bresp_i[i*2 +: 2];
                mux_user |= buser_i[i*AXI_USER +: AXI_USER];
            end
        end
        if (gnt[N_TARG_PORT]) begin
            mux_id   |= error_id_i;
            mux_resp |= RESP_DECERR;
            mux_user |= error_user_i;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        is_err_d = is_err_q;
        id_d     = id_q;
        resp_d   = resp_q;
        user_d   = user_q;
        if (load) begin
            valid_d  = 1'b1;
            is_err_d = gnt[N_TARG_PORT];
            id_d     = mux_id;
            resp_d   = mux_resp;
            user_d   = mux_user;
        end else if (bready_i) begin
            valid_d  = 1'b0;
        end
    end

    // Error responses never had a matching AW increment, so they are not counted down.
    assign dec = valid_q && bready_i && !is_err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (incr_req_i && !dec) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !incr_req_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            is_err_q <= 1'b0;
            id_q     <= '0;
            resp_q   <= '0;
            user_q   <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            is_err_q <= is_err_d;
            id_q     <= id_d;
            resp_q   <= resp_d;
            user_q   <= user_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bready_o            = gnt[N_TARG_PORT-1:0];
    assign error_gnt_o         = gnt[N_TARG_PORT];
    assign bvalid_o            = valid_q;
    assign bid_o               = id_q;
    assign bresp_o             = resp_q;
    assign buser_o             = user_q;
    assign full_counter_o      = (cnt_q == CNT_MAX);
    assign outstanding_trans_o = (cnt_q != '0);

    a_b_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bvalid_o && !bready_i |=> bvalid_o && $stable(bid_o) && $stable(bresp_o) && $stable(buser_o));
    a_no_gnt_stall: assert property (@(posedge clk) disable iff (!rst_n)
        bvalid_o && !bready_i |-> !(|bready_o) && !error_gnt_o);
    a_err_id_stable: assert property (@(posedge clk) disable iff (!rst_n)
        error_req_i && !error_gnt_o |=> !error_req_i || $stable(error_id_i));
    a_cnt_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(incr_req_i && !dec && full_counter_o));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !incr_req_i && !outstanding_trans_o));

endmodule
